// File: rtl/tbus_arbiter.sv
// rtl/tbus_arbiter.sv - round-robin owner arbiter and break-before-make sequencer for a TINV-driven shared bus
// Optional idle parking of bank PARK_ID on the bus is enabled by defining TBUS_PARK_EN.
module tbus_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DEAD_CYCLES = 1,
    parameter int HOLD_MAX    = 8,
    parameter int PARK_ID     = 0
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [N_REQ-1:0] REQ,
    output logic [N_REQ-1:0] GNT,
    output logic [N_REQ-1:0] EN,
    output logic [N_REQ-1:0] nEN,
    output logic             BUSY
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [HW-1:0] HOLD_LIM  = HW'(HOLD_MAX);
    localparam logic [1:0]    DEAD_INIT = 2'(DEAD_CYCLES - 1);

    generate
        if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
            $error("tbus_arbiter: N_REQ must be in 2..8");
        end
        if (DEAD_CYCLES < 1 || DEAD_CYCLES > 3) begin : g_bad_dead
            $error("tbus_arbiter: DEAD_CYCLES must be in 1..3");
        end
        if (PARK_ID < 0 || PARK_ID >= N_REQ) begin : g_bad_park
            $error("tbus_arbiter: PARK_ID out of range");
        end
        if (HOLD_MAX < 0) begin : g_bad_hold
            $error("tbus_arbiter: HOLD_MAX must be non-negative");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [PW-1:0]     rr_ptr, rr_d;
    logic [PW-1:0]     owner, owner_d;
    logic [HW-1:0]     hold_cnt, hold_d;
    logic [1:0]        dead_cnt, dead_d;
    logic [N_REQ-1:0]  gnt_d, en_d;

    logic              any_req;
    logic [PW-1:0]     win;
    logic              others_waiting;
    logic              hold_hit;
    logic              release_owner;
    logic              leave_park;

    function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // First requester at or after ptr, wrapping; ptr itself when nobody asks.
    function automatic logic [PW-1:0] pick_winner(input logic [N_REQ-1:0] r,
                                                  input logic [PW-1:0]    ptr);
        logic [PW-1:0] w;
        logic          found;
        int            idx;
        w     = ptr;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && r[PW'(idx)]) begin
                w     = PW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign any_req        = |REQ;
    assign win            = pick_winner(REQ, rr_ptr);
    assign others_waiting = |(REQ & ~onehot(owner));
    assign hold_hit       = (HOLD_MAX != 0) && (hold_cnt >= HOLD_LIM);
    assign release_owner  = !REQ[owner] || (hold_hit && others_waiting);

`ifdef TBUS_PARK_EN
    localparam logic [PW-1:0] PARK_IDX = PW'(PARK_ID);
    // A parked bank may hand over to itself directly; any other winner needs a full dead time.
    assign leave_park = EN[PARK_IDX] && (win != PARK_IDX);
`else
    assign leave_park = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            hold_cnt <= '0;
            dead_cnt <= '0;
            GNT      <= '0;
            EN       <= '0;
            nEN      <= '1;
            BUSY     <= 1'b0;
        end else begin
            state    <= state_d;
            rr_ptr   <= rr_d;
            owner    <= owner_d;
            hold_cnt <= hold_d;
            dead_cnt <= dead_d;
            GNT      <= gnt_d;
            EN       <= en_d;
            nEN      <= ~en_d;
            BUSY     <= |gnt_d;
        end
    end

    always_comb begin
        state_d = state;
        rr_d    = rr_ptr;
        owner_d = owner;
        hold_d  = hold_cnt;
        dead_d  = dead_cnt;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    if (leave_park) begin
                        state_d = S_TURN;
                        dead_d  = DEAD_INIT;
                    end else begin
                        state_d = S_GRANT;
                        owner_d = win;
                        hold_d  = HW'(1);
                    end
                end
            end
            S_GRANT: begin
                if (release_owner) begin
                    state_d = S_TURN;
                    rr_d    = (owner == PW'(N_REQ - 1)) ? '0 : owner + PW'(1);
                    dead_d  = DEAD_INIT;
                end else if (HOLD_MAX != 0 && hold_cnt < HOLD_LIM) begin
                    hold_d = hold_cnt + HW'(1);
                end
            end
            S_TURN: begin
                if (dead_cnt != 2'd0) begin
                    dead_d = dead_cnt - 2'd1;
                end else if (any_req) begin
                    state_d = S_GRANT;
                    owner_d = win;
                    hold_d  = HW'(1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        gnt_d = '0;
        en_d  = '0;
        if (state_d == S_GRANT) begin
            gnt_d = onehot(owner_d);
            en_d  = onehot(owner_d);
        end
`ifdef TBUS_PARK_EN
        // Park only from a settled IDLE, so the cycle after TURN still floats.
        if (state == S_IDLE && state_d == S_IDLE) begin
            en_d[PARK_IDX] = 1'b1;
        end
`endif
    end

endmodule

// File: doc/tbus_arbiter.md
Name: tbus_arbiter

Overview:
- Round-robin arbiter and driver sequencer for a shared tri-state bus built from TINV cells.
- Each requester owns one bank of TINV drivers. The arbiter produces per-requester grant plus the complementary EN/nEN pair that feeds the TINV enables.
- Guarantees: never more than one bank enabled at once, and a programmable break-before-make dead time between owners.
- Sits between the datapath sources (register file read port, ALU result, memory data) and the shared result bus.

Parameters:
- N_REQ, 4: number of requesters/driver banks (2..8).
- DEAD_CYCLES, 1: full cycles with all banks disabled between two different owners (1..3).
- HOLD_MAX, 8: max grant cycles while another requester is waiting; 0 = unlimited.
- PARK_ID, 0: bank enabled while idle (used only with TBUS_PARK_EN).

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- REQ  in  N_REQ  level request, held for the whole transfer.
- GNT  out  N_REQ  one-hot-or-zero grant to requester logic.
- EN  out  N_REQ  TINV enable per bank, registered.
- nEN  out  N_REQ  exact complement of EN, registered, feeds TINV nEN.
- BUSY  out  1  1 when GNT != 0.

Behaviour:
- One clock; reset is asynchronous and active-low on nRST. All outputs registered.
- Reset values, applied immediately and asynchronously, including mid-transfer:
  - GNT=0, EN=0, nEN=all 1s, BUSY=0.
  - State IDLE, rr_ptr=0, counters=0.
- States: IDLE, GRANT, TURN.
- Winner selection: the first requester with REQ=1, scanning from rr_ptr upward and wrapping modulo N_REQ.
- IDLE:
  - If any REQ is high, the winner gets GNT and EN at the next edge (1-cycle latency); state goes to GRANT and hold_cnt=1.
  - Otherwise stay in IDLE.
- GRANT (owner g):
  - Release occurs when REQ[g]=0, or when HOLD_MAX!=0, hold_cnt>=HOLD_MAX, and another REQ is high.
  - On the releasing edge: GNT=0, EN=0, rr_ptr=(g+1) mod N_REQ, state TURN, dead_cnt=DEAD_CYCLES-1.
  - Otherwise hold_cnt increments, saturating at HOLD_MAX.
  - If the owner keeps REQ high and no other requester is waiting, the grant is held indefinitely.
- TURN:
  - All EN=0.
  - If dead_cnt!=0, decrement it.
  - If dead_cnt==0 and a REQ is pending, grant the winner directly and go to GRANT. With no REQ pending, go to IDLE.
  - Net effect: exactly DEAD_CYCLES cycles with no bank enabled between owners.
- A requester dropping and re-raising REQ during TURN is treated as new. It is not the preferred winner, because rr_ptr has already advanced.
- Simultaneous requests: rr_ptr order only; no fixed priority.
- Invariants (assert in the bench):
  - popcount(EN)<=1 always.
  - nEN==~EN always.
  - GNT==EN except in park mode.
  - Any change of the enabled bank is preceded by >=DEAD_CYCLES cycles with EN==0.
- An out-of-range PARK_ID or DEAD_CYCLES is a synthesis-time error, raised via a generate-time check.

Optional Feature:
- Macro: TBUS_PARK_EN.
- Defined:
  - In IDLE, EN[PARK_ID]=1 and nEN[PARK_ID]=0 while GNT=0, so the bus never floats.
  - Park is entered 1 cycle after TURN exits to IDLE. Reset still forces all EN=0 until the first edge after nRST rises.
  - Leaving park for winner==PARK_ID: GNT rises with no dead time.
  - Leaving park for any other winner: EN drops, then TURN with DEAD_CYCLES, then grant.
- Not defined: the bus floats while idle, with EN=0 in IDLE.

Test Plan:
- Reset with REQ=4'b0001, then release nRST → GNT=0001 at first edge+1, EN=0001, nEN=1110, BUSY=1.
- REQ[0] high, then REQ[0] low at cycle 10 while REQ[2] high (DEAD_CYCLES=2) → EN=0000 for cycles 11-12, GNT=0100 at cycle 13.
- REQ=1111 held continuously, HOLD_MAX=8 → grants rotate 0,1,2,3,0, each 8 cycles, with 1 dead cycle between; popcount(EN)<=1 throughout.
- REQ[1] alone held for 100 cycles → GNT=0010 uninterrupted (no preemption without competitors).
- nRST pulsed low mid-grant → EN=0000 and nEN=1111 within the same cycle, without waiting for CLK; after release, arbitration restarts at rr_ptr=0.
- TBUS_PARK_EN, PARK_ID=0, idle → EN=0001, GNT=0000. REQ[3] rises → EN=0000 for DEAD_CYCLES, then GNT=EN=1000.
